// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
// Bit 0 is the MSB of every bus; WB_FWD_EN enables the forwarding register.
package wb_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LOAD,
    WB_LINK
  } wb_sel_e;

  typedef struct packed {
    logic [0:REG_IDX_W-1] rw;
    logic [0:XLEN-1]      data;
  } fpu_entry_t;

  // Extract a byte/halfword/word from an aligned memory word and extend it.
  function automatic logic [0:XLEN-1] load_align(
    input logic [0:XLEN-1] rdata,
    input logic [0:1]      off,
    input logic            is_byte,
    input logic            is_half,
    input logic            sext
  );
    logic [0:7]  b;
    logic [0:15] h;
    b = rdata[0:7];
    case (off)
      2'd1:    b = rdata[8:15];
      2'd2:    b = rdata[16:23];
      2'd3:    b = rdata[24:31];
      default: b = rdata[0:7];
    endcase
    h = off[0] ? rdata[16:31] : rdata[0:15];
    if (is_byte)      load_align = {{24{sext & b[0]}}, b};
    else if (is_half) load_align = {{16{sext & h[0]}}, h};
    else              load_align = rdata;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-side, FPU completion, writeback and forwarding signals of the writeback stage.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                 mem_valid;
  logic                 mem_reg_we;
  logic                 mem_freg_we;
  logic [0:REG_IDX_W-1] mem_rw;
  logic [0:XLEN-1]      mem_alu_result;
  logic [0:XLEN-1]      mem_rdata;
  logic                 mem_to_reg;
  logic                 mem_byte_op;
  logic                 mem_halfword_op;
  logic                 mem_sign_ext;
  logic                 mem_jal;
  logic [0:XLEN-1]      mem_link;

  logic                 fpu_valid;
  logic [0:REG_IDX_W-1] fpu_rw;
  logic [0:XLEN-1]      fpu_result;
  logic                 fpu_ready;

  logic                 reg_we_out;
  logic                 freg_we_out;
  logic [0:REG_IDX_W-1] Rw_out;
  logic [0:REG_IDX_W-1] FRw_out;
  logic [0:XLEN-1]      BUS_W;
  logic [0:XLEN-1]      FBUS_W;

  logic                 fwd_valid;
  logic [0:REG_IDX_W-1] fwd_rw;
  logic [0:XLEN-1]      fwd_data;

  modport master (
    output mem_valid, mem_reg_we, mem_freg_we, mem_rw, mem_alu_result, mem_rdata,
           mem_to_reg, mem_byte_op, mem_halfword_op, mem_sign_ext, mem_jal, mem_link,
           fpu_valid, fpu_rw, fpu_result,
    input  fpu_ready, reg_we_out, freg_we_out, Rw_out, FRw_out, BUS_W, FBUS_W,
           fwd_valid, fwd_rw, fwd_data
  );

  modport slave (
    input  mem_valid, mem_reg_we, mem_freg_we, mem_rw, mem_alu_result, mem_rdata,
           mem_to_reg, mem_byte_op, mem_halfword_op, mem_sign_ext, mem_jal, mem_link,
           fpu_valid, fpu_rw, fpu_result,
    output fpu_ready, reg_we_out, freg_we_out, Rw_out, FRw_out, BUS_W, FBUS_W,
           fwd_valid, fwd_rw, fwd_data
  );

endinterface

// File: rtl/wb_stage_fpu_fifo.sv
// Two-entry FPU result queue with empty-queue bypass so a result offered
// while the FPR port is free is written in the very next cycle.
module wb_fpu_fifo
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push_valid,
  input  fpu_entry_t i_push_data,
  input  logic       i_pop_en,
  output logic       o_ready,
  output logic       o_pop_valid,
  output fpu_entry_t o_pop_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fpu_entry_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_store;
  logic w_take;

  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = i_push_valid & ~w_full;
  assign w_pop    = i_pop_en & (~w_empty | w_push);
  assign w_bypass = w_empty & w_push & w_pop;
  assign w_store  = w_push & ~w_bypass;
  assign w_take   = w_pop & ~w_bypass;

  assign o_ready     = ~w_full;
  assign o_pop_valid = w_pop;
  assign o_pop_data  = w_empty ? i_push_data : r_mem[r_rd_ptr];

  // Depth is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_store) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_take) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_store, w_take})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load alignment, GPR/FPR write ports and
// optional one-cycle forwarding of the committed GPR write (macro WB_FWD_EN).
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  wb_sel_e              w_sel;
  logic [0:XLEN-1]      w_load_data;
  logic [0:XLEN-1]      w_gpr_data;
  logic                 w_pipe_fwe;
  logic                 w_pop_valid;
  fpu_entry_t           w_pop_data;
  fpu_entry_t           w_push_data;

  logic                 r_reg_we;
  logic                 r_freg_we;
  logic [0:REG_IDX_W-1] r_rw;
  logic [0:REG_IDX_W-1] r_frw;
  logic [0:XLEN-1]      r_bus_w;
  logic [0:XLEN-1]      r_fbus_w;

  // GPR data source selection and load alignment.
  always_comb begin
    w_sel = WB_ALU;
    if (bus.mem_jal)         w_sel = WB_LINK;
    else if (bus.mem_to_reg) w_sel = WB_LOAD;
    w_load_data = load_align(bus.mem_rdata, bus.mem_alu_result[30:31],
                             bus.mem_byte_op, bus.mem_halfword_op, bus.mem_sign_ext);
    case (w_sel)
      WB_LINK: w_gpr_data = bus.mem_link;
      WB_LOAD: w_gpr_data = w_load_data;
      default: w_gpr_data = bus.mem_alu_result;
    endcase
  end

  assign w_pipe_fwe  = bus.mem_valid & bus.mem_freg_we;
  assign w_push_data = '{rw: bus.fpu_rw, data: bus.fpu_result};

  wb_fpu_fifo u_fpu_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (bus.fpu_valid),
    .i_push_data  (w_push_data),
    .i_pop_en     (~w_pipe_fwe),
    .o_ready      (bus.fpu_ready),
    .o_pop_valid  (w_pop_valid),
    .o_pop_data   (w_pop_data)
  );

  // MEM/WB register; pipeline FPR writes take priority over the FPU queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_we  <= 1'b0;
      r_freg_we <= 1'b0;
      r_rw      <= '0;
      r_frw     <= '0;
      r_bus_w   <= '0;
      r_fbus_w  <= '0;
    end else begin
      r_reg_we  <= bus.mem_valid & bus.mem_reg_we & (bus.mem_rw != '0);
      r_freg_we <= w_pipe_fwe | w_pop_valid;
      if (bus.mem_valid) begin
        r_rw    <= bus.mem_rw;
        r_bus_w <= w_gpr_data;
      end
      if (w_pipe_fwe) begin
        r_frw    <= bus.mem_rw;
        r_fbus_w <= w_gpr_data;
      end else if (w_pop_valid) begin
        r_frw    <= w_pop_data.rw;
        r_fbus_w <= w_pop_data.data;
      end
    end
  end

  assign bus.reg_we_out  = r_reg_we;
  assign bus.freg_we_out = r_freg_we;
  assign bus.Rw_out      = r_rw;
  assign bus.FRw_out     = r_frw;
  assign bus.BUS_W       = r_bus_w;
  assign bus.FBUS_W      = r_fbus_w;

`ifdef WB_FWD_EN
  logic                 r_fwd_valid;
  logic [0:REG_IDX_W-1] r_fwd_rw;
  logic [0:XLEN-1]      r_fwd_data;

  // Delayed copy of the committed GPR write, visible for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwd_valid <= 1'b0;
      r_fwd_rw    <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= r_reg_we;
      r_fwd_rw    <= r_rw;
      r_fwd_data  <= r_bus_w;
    end
  end

  assign bus.fwd_valid = r_fwd_valid;
  assign bus.fwd_rw    = r_fwd_rw;
  assign bus.fwd_data  = r_fwd_data;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rw    = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (honours WB_FWD_EN if defined).
module tb_wb_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  wb_stage_if bus ();

  wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.mem_valid       = 1'b0;
    bus.mem_reg_we      = 1'b0;
    bus.mem_freg_we     = 1'b0;
    bus.mem_rw          = '0;
    bus.mem_alu_result  = '0;
    bus.mem_rdata       = '0;
    bus.mem_to_reg      = 1'b0;
    bus.mem_byte_op     = 1'b0;
    bus.mem_halfword_op = 1'b0;
    bus.mem_sign_ext    = 1'b0;
    bus.mem_jal         = 1'b0;
    bus.mem_link        = '0;
    bus.fpu_valid       = 1'b0;
    bus.fpu_rw          = '0;
    bus.fpu_result      = '0;
  endtask

  task automatic load(input logic [4:0] rw, input logic [31:0] addr, input logic [31:0] rdata,
                      input logic is_byte, input logic is_half, input logic sext);
    idle();
    bus.mem_valid       = 1'b1;
    bus.mem_reg_we      = 1'b1;
    bus.mem_rw          = rw;
    bus.mem_alu_result  = addr;
    bus.mem_rdata       = rdata;
    bus.mem_to_reg      = 1'b1;
    bus.mem_byte_op     = is_byte;
    bus.mem_halfword_op = is_half;
    bus.mem_sign_ext    = sext;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    reset = 1'b0;
    #12;
    check("rst_reg_we",    32'(bus.reg_we_out),  32'd0);
    check("rst_freg_we",   32'(bus.freg_we_out), 32'd0);
    check("rst_rw",        32'(bus.Rw_out),      32'd0);
    check("rst_bus_w",     32'(bus.BUS_W),       32'd0);
    check("rst_fbus_w",    32'(bus.FBUS_W),      32'd0);
    check("rst_fwd_valid", 32'(bus.fwd_valid),   32'd0);
    check("rst_fpu_ready", 32'(bus.fpu_ready),   32'd1);
    step();
    reset = 1'b1;

    // lb, offset 2, sign-extended
    load(5'd4, 32'h0000_0102, 32'h1122_8344, 1'b1, 1'b0, 1'b1);
    step();
    check("lb_we",  32'(bus.reg_we_out), 32'd1);
    check("lb_rw",  32'(bus.Rw_out),     32'd4);
    check("lb_bus", 32'(bus.BUS_W),      32'hFFFF_FF83);

    // lhu, offset 2
    load(5'd5, 32'h0000_0102, 32'h1234_ABCD, 1'b0, 1'b1, 1'b0);
    step();
    check("lhu_we",  32'(bus.reg_we_out), 32'd1);
    check("lhu_bus", 32'(bus.BUS_W),      32'h0000_ABCD);

    // same access to R0 must not write
    load(5'd0, 32'h0000_0102, 32'h1234_ABCD, 1'b0, 1'b1, 1'b0);
    step();
    check("r0_we", 32'(bus.reg_we_out), 32'd0);

    // lh offset 0, sign-extended
    load(5'd6, 32'h0000_0100, 32'h8001_7FFF, 1'b0, 1'b1, 1'b1);
    step();
    check("lh_bus", 32'(bus.BUS_W), 32'hFFFF_8001);

    // lbu offset 3, zero-extended
    load(5'd8, 32'h0000_0103, 32'h1122_83F4, 1'b1, 1'b0, 1'b0);
    step();
    check("lbu_bus", 32'(bus.BUS_W), 32'h0000_00F4);

    // lw full word
    load(5'd9, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
    step();
    check("lw_bus", 32'(bus.BUS_W), 32'hCAFE_F00D);

    // ALU result path
    idle();
    bus.mem_valid = 1'b1; bus.mem_reg_we = 1'b1; bus.mem_rw = 5'd10;
    bus.mem_alu_result = 32'h1234_5678; bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    check("alu_rw",  32'(bus.Rw_out), 32'd10);
    check("alu_bus", 32'(bus.BUS_W),  32'h1234_5678);

    // jal link
    idle();
    bus.mem_valid = 1'b1; bus.mem_reg_we = 1'b1; bus.mem_rw = 5'd31;
    bus.mem_jal = 1'b1; bus.mem_to_reg = 1'b1; bus.mem_link = 32'h0000_0108;
    bus.mem_alu_result = 32'h0000_0500;
    step();
    check("jal_rw",  32'(bus.Rw_out), 32'd31);
    check("jal_bus", 32'(bus.BUS_W),  32'h0000_0108);

    // GPR write of DEADBEEF to R7, then bubbles
    idle();
    bus.mem_valid = 1'b1; bus.mem_reg_we = 1'b1; bus.mem_rw = 5'd7;
    bus.mem_alu_result = 32'hDEAD_BEEF;
    step();
    check("r7_we", 32'(bus.reg_we_out), 32'd1);
    idle();
    step();
    check("bubble_we", 32'(bus.reg_we_out), 32'd0);
`ifdef WB_FWD_EN
    check("fwd_valid", 32'(bus.fwd_valid), 32'd1);
    check("fwd_rw",    32'(bus.fwd_rw),    32'd7);
    check("fwd_data",  32'(bus.fwd_data),  32'hDEAD_BEEF);
`else
    check("fwd_off_valid", 32'(bus.fwd_valid), 32'd0);
    check("fwd_off_data",  32'(bus.fwd_data),  32'd0);
`endif
    step();
    check("fwd_after_bubble", 32'(bus.fwd_valid), 32'd0);

    // Three FPU offers against two pipeline FPR writes
    idle();
    bus.mem_valid = 1'b1; bus.mem_freg_we = 1'b1; bus.mem_rw = 5'd2;
    bus.mem_alu_result = 32'hAAAA_0001;
    bus.fpu_valid = 1'b1; bus.fpu_rw = 5'd10; bus.fpu_result = 32'h1000_000A;
    #1 check("fifo_rdy0", 32'(bus.fpu_ready), 32'd1);
    step();
    check("pipe1_fwe", 32'(bus.freg_we_out), 32'd1);
    check("pipe1_frw", 32'(bus.FRw_out),     32'd2);
    check("pipe1_fbus", 32'(bus.FBUS_W),     32'hAAAA_0001);
    bus.mem_rw = 5'd3; bus.mem_alu_result = 32'hAAAA_0002;
    bus.fpu_rw = 5'd11; bus.fpu_result = 32'h1000_000B;
    #1 check("fifo_rdy1", 32'(bus.fpu_ready), 32'd1);
    step();
    check("pipe2_frw", 32'(bus.FRw_out), 32'd3);
    bus.mem_valid = 1'b0; bus.mem_freg_we = 1'b0;
    bus.fpu_rw = 5'd12; bus.fpu_result = 32'h1000_000C;
    #1 check("fifo_full_rdy", 32'(bus.fpu_ready), 32'd0);
    step();
    check("pop1_fwe",  32'(bus.freg_we_out), 32'd1);
    check("pop1_frw",  32'(bus.FRw_out),     32'd10);
    check("pop1_fbus", 32'(bus.FBUS_W),      32'h1000_000A);
    #1 check("fifo_rdy2", 32'(bus.fpu_ready), 32'd1);
    step();
    check("pop2_frw",  32'(bus.FRw_out), 32'd11);
    check("pop2_fbus", 32'(bus.FBUS_W),  32'h1000_000B);
    bus.fpu_valid = 1'b0;
    step();
    check("pop3_fwe",  32'(bus.freg_we_out), 32'd1);
    check("pop3_frw",  32'(bus.FRw_out),     32'd12);
    check("pop3_fbus", 32'(bus.FBUS_W),      32'h1000_000C);
    step();
    check("fifo_drained", 32'(bus.freg_we_out), 32'd0);

    // Empty FIFO bypass: offer in cycle N written in N+1
    bus.fpu_valid = 1'b1; bus.fpu_rw = 5'd13; bus.fpu_result = 32'h0BAD_CAFE;
    step();
    check("byp_fwe",  32'(bus.freg_we_out), 32'd1);
    check("byp_frw",  32'(bus.FRw_out),     32'd13);
    check("byp_fbus", 32'(bus.FBUS_W),      32'h0BAD_CAFE);
    bus.fpu_valid = 1'b0;
    step();
    check("byp_done", 32'(bus.freg_we_out), 32'd0);

    // Fill the queue, then reset mid-cycle
    idle();
    bus.mem_valid = 1'b1; bus.mem_freg_we = 1'b1; bus.mem_reg_we = 1'b1;
    bus.mem_rw = 5'd14; bus.mem_alu_result = 32'h5555_0001;
    bus.fpu_valid = 1'b1; bus.fpu_rw = 5'd20; bus.fpu_result = 32'h2000_0014;
    step();
    bus.fpu_rw = 5'd21; bus.fpu_result = 32'h2000_0015;
    step();
    idle();
    #1 check("pre_rst_full", 32'(bus.fpu_ready), 32'd0);
    check("pre_rst_we", 32'(bus.reg_we_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_reg_we",  32'(bus.reg_we_out),  32'd0);
    check("mid_rst_freg_we", 32'(bus.freg_we_out), 32'd0);
    check("mid_rst_rw",      32'(bus.Rw_out),      32'd0);
    check("mid_rst_frw",     32'(bus.FRw_out),     32'd0);
    check("mid_rst_bus",     32'(bus.BUS_W),       32'd0);
    check("mid_rst_fbus",    32'(bus.FBUS_W),      32'd0);
    check("mid_rst_fwd",     32'(bus.fwd_valid),   32'd0);
    check("mid_rst_ready",   32'(bus.fpu_ready),   32'd1);
    step();
    reset = 1'b1;
    step();
    check("post_rst_fwe0", 32'(bus.freg_we_out), 32'd0);
    step();
    check("post_rst_fwe1", 32'(bus.freg_we_out), 32'd0);
    check("post_rst_rdy",  32'(bus.fpu_ready),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock (all state on rising edge); reset  in  1  async active-low reset.
REQ-002 SHALL have MEM-side inputs, sampled when mem_valid=1:
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_reg_we  in  1  GPR write request
- mem_freg_we  in  1  FPR write request
- mem_rw  in  [0:4]  destination register
- mem_alu_result  in  [0:31]  ALU result / load address
- mem_rdata  in  [0:31]  aligned data-memory word
- mem_to_reg, mem_byte_op, mem_halfword_op, mem_sign_ext, mem_jal  in  1 each  load/JAL controls
- mem_link  in  [0:31]  JAL return address
REQ-003 SHALL have an FPU completion port: fpu_valid  in  1  result offered; fpu_rw  in  [0:4]  destination FPR; fpu_result  in  [0:31]  result; fpu_ready  out  1  queue can accept.
REQ-004 SHALL have writeback outputs to decode: reg_we_out  out  1; freg_we_out  out  1; Rw_out  out  [0:4]  GPR destination; FRw_out  out  [0:4]  FPR destination; BUS_W  out  [0:31]  GPR data; FBUS_W  out  [0:31]  FPR data.
REQ-005 SHALL have forwarding outputs: fwd_valid  out  1; fwd_rw  out  [0:4]; fwd_data  out  [0:31].

Function
REQ-006 Bit 0 SHALL be the MSB of every bus. Byte offset = mem_alu_result[30:31]; offset 0 selects bits [0:7].
REQ-007 When mem_valid=1, SHALL register one MEM/WB entry per cycle; the GPR write appears on outputs exactly one cycle later. When mem_valid=0, the entry is a bubble with no writes.
REQ-008 GPR data selection SHALL be: mem_jal -> mem_link; else mem_to_reg -> load data; else mem_alu_result.
REQ-009 Load data SHALL be:
- byte op: selected byte;
- halfword op: halfword at offset[0] (offset 0 -> [0:15], offset 2 -> [16:31]);
- otherwise the full word.
- Subword loads sign-extend when mem_sign_ext=1 and zero-extend when it is 0.
REQ-010 reg_we_out SHALL be forced to 0 when Rw_out=0 (R0 is never written).
REQ-011 FPU results SHALL enter a 2-entry FIFO on fpu_valid&&fpu_ready. fpu_ready = !full. An fpu_valid while full is ignored, and the FPU holds it.
REQ-012 The FPR write port SHALL have fixed priority: a registered pipeline FPR write (mem_freg_we) first; otherwise the FIFO head pops. freg_we_out is registered.
REQ-013 Enqueue and dequeue in the same cycle SHALL keep the occupancy count. With an empty FIFO and no pipeline FPR write, an FPU result enqueued in cycle N SHALL be written in cycle N+1.
REQ-014 The FIFO SHALL use pointer wrap modulo 2. Full = count 2; empty = count 0.
REQ-015 Forwarding: fwd_* SHALL present the GPR write committed in the previous cycle (value, Rw) for exactly one cycle. fwd_valid=0 after a bubble or an R0 write.

Reset
REQ-016 While reset=0, SHALL asynchronously clear:
- reg_we_out, freg_we_out, fwd_valid = 0
- Rw_out, FRw_out, fwd_rw = 0
- BUS_W, FBUS_W, fwd_data = 0
- FIFO pointers and count = 0
REQ-017 fpu_ready SHALL be 1 in reset. Reset mid-operation SHALL discard queued FPU results and any pending writes.

Configuration
REQ-018 Macro WB_FWD_EN defined: SHALL implement REQ-015. Undefined: fwd_valid, fwd_rw and fwd_data SHALL be tied to 0, and the forwarding register SHALL NOT be synthesized.

Structure
REQ-019 A shared package SHALL hold:
- the writeback-select enum {WB_ALU, WB_LOAD, WB_LINK}
- the FIFO depth constant (2)
- the register-index width constant (5)
REQ-020 The FPU result queue SHALL be the sub-module wb_fpu_fifo.

Verification
REQ-021 lb, mem_alu_result=0x00000102, mem_rdata=0x11228344, mem_sign_ext=1, mem_rw=4 -> next cycle: reg_we_out=1, Rw_out=4, BUS_W=0xFFFFFF83.
REQ-022 lhu, offset 2, mem_rdata=0x1234ABCD, mem_sign_ext=0 -> BUS_W=0x0000ABCD. The same access with mem_rw=0 -> reg_we_out=0.
REQ-023 jal, mem_link=0x00000108 -> Rw_out=31, BUS_W=0x00000108.
REQ-024 Three back-to-back fpu_valid, with mem_freg_we=1 on the first two cycles:
- third offer sees fpu_ready=0 and is not accepted;
- queued results are written in FIFO order once the pipeline FPR writes end;
- no result is lost.
REQ-025 Assert reset=0 mid-cycle with 2 queued entries -> all outputs are 0 immediately and fpu_ready=1. After release, no stale FPR write occurs.
REQ-026 With WB_FWD_EN: a GPR write of 0xDEADBEEF to R7 -> next cycle fwd_valid=1, fwd_rw=7, fwd_data=0xDEADBEEF, then fwd_valid=0 after a bubble. Without WB_FWD_EN: fwd_valid stays 0.
